// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: ID-stage detection of the hazards that EXE forwarding
// cannot cover (load-use, branch operands compared in ID, mult/div busy).
// Drives PC / IF/ID / ID/EX controls and tracks the mult/div unit with a
// small IDLE/BUSY FSM and a down-counter.
//
// state | meaning
// IDLE  | mult/div unit free; an unstalled start in ID is accepted
// BUSY  | mult/div unit running; cnt holds remaining busy cycles
module hazard_stall_unit #(
    parameter int MD_LATENCY = 32,
    parameter int CNT_W      = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       MemRead_EXE,
    input  logic       RegWrite_EXE,
    input  logic [4:0] DstReg_EXE,
    input  logic       MemRead_MEM,
    input  logic [4:0] DstReg_MEM,
    input  logic [4:0] Rs_ID,
    input  logic [4:0] Rt_ID,
    input  logic       UsesRs_ID,
    input  logic       UsesRt_ID,
    input  logic       Branch_ID,
    input  logic       BranchTaken_ID,
    input  logic       Jump_ID,
    input  logic       MDStart_ID,
    input  logic       HiLoRead_ID,
    output logic       PC_Write,
    output logic       IFID_Write,
    output logic       IFID_Flush,
    output logic       IDEX_Flush,
    output logic       MD_Busy,
    output logic [1:0] Stall_Cause
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;

    logic exe_match, mem_match;
    logic load_use, br_haz, md_haz, stall;

    // Register 0 is hardwired, so it never produces a dependency.
    assign exe_match = (DstReg_EXE != 5'd0) &&
                       ((UsesRs_ID && (DstReg_EXE == Rs_ID)) ||
                        (UsesRt_ID && (DstReg_EXE == Rt_ID)));
    assign mem_match = (DstReg_MEM != 5'd0) &&
                       ((UsesRs_ID && (DstReg_MEM == Rs_ID)) ||
                        (UsesRt_ID && (DstReg_MEM == Rt_ID)));

    assign load_use = MemRead_EXE && exe_match;
    // Branches compare in ID, so any in-flight producer of an operand stalls;
    // a load one stage ahead in MEM is still not forwardable to ID.
    assign br_haz   = Branch_ID && ((RegWrite_EXE && exe_match) ||
                                    (MemRead_MEM && mem_match));
    assign md_haz   = (state == BUSY) && (MDStart_ID || HiLoRead_ID);
    assign stall    = load_use || br_haz || md_haz;

    assign MD_Busy  = (state == BUSY);

    // Pipeline control outputs; reset forces a free-running, unflushed pipeline.
    always_comb begin
        PC_Write    = 1'b1;
        IFID_Write  = 1'b1;
        IFID_Flush  = 1'b0;
        IDEX_Flush  = 1'b0;
        Stall_Cause = 2'd0;
        if (!rst) begin
            PC_Write   = !stall;
            IFID_Write = !stall;
            IDEX_Flush = stall;
            // A stalled control transfer waits; its squash happens once it moves.
            IFID_Flush = (Jump_ID || (Branch_ID && BranchTaken_ID)) && !stall;
            if (load_use)
                Stall_Cause = 2'd1;
            else if (br_haz)
                Stall_Cause = 2'd2;
            else if (md_haz)
                Stall_Cause = 2'd3;
        end
    end

    // Next-state logic for the mult/div busy tracker; it counts through stalls.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (MDStart_ID && !stall) begin
                    state_next = BUSY;
                    cnt_next   = CNT_W'(MD_LATENCY);
                end
            end
            BUSY: begin
                if (cnt == CNT_W'(1)) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // State and counter registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

endmodule
